// File: rtl/upload_arbiter_if.sv
// Handshake bundle between per-channel upload sources and the merged downstream stream.
// master: arbiter side; slave: sources plus downstream sink.
interface upload_arbiter_if #(
    parameter int unsigned NUM_CHANNELS = 2
);
    logic [NUM_CHANNELS-1:0]   in_req;
    logic [NUM_CHANNELS*8-1:0] in_data;
    logic [NUM_CHANNELS*8-1:0] in_source;
    logic [NUM_CHANNELS-1:0]   in_valid;
    logic [NUM_CHANNELS-1:0]   in_ready;
    logic                      merged_req;
    logic [7:0]                merged_data;
    logic [7:0]                merged_source;
    logic                      merged_valid;
    logic                      merged_ready;
    logic [2:0]                active_channel;
    logic                      timeout_pulse;

    modport master (
        input  in_req, in_data, in_source, in_valid, merged_ready,
        output in_ready, merged_req, merged_data, merged_source, merged_valid,
        output active_channel, timeout_pulse
    );

    modport slave (
        output in_req, in_data, in_source, in_valid, merged_ready,
        input  in_ready, merged_req, merged_data, merged_source, merged_valid,
        input  active_channel, timeout_pulse
    );
endinterface

// File: rtl/upload_arbiter.sv
// Round-robin arbiter merging packed upload channels into one framed byte stream,
// with a stall watchdog that revokes a grant held without progress.
module upload_arbiter #(
    parameter int unsigned NUM_CHANNELS   = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic             clk,
    input  logic             rst_n,
    upload_arbiter_if.master bus_io
);
    typedef enum logic [1:0] {StIdle, StActive, StRelease} state_e;

    state_e      state_q, state_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [2:0]  grant_idx_q, grant_idx_d;
    logic [15:0] stall_q, stall_d;

    logic       pick_found;
    logic [2:0] pick_idx;
    logic       sel_req;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic [7:0] sel_source;
    logic       xfer;

    // First requester at or after rr_ptr, wrapping modulo NUM_CHANNELS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                if (!pick_found && bus_io.in_req[i] &&
                    (i == (32'(rr_ptr_q) + k) % NUM_CHANNELS)) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        sel_req    = 1'b0;
        sel_valid  = 1'b0;
        sel_data   = 8'h00;
        sel_source = 8'h00;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (32'(grant_idx_q) == i) begin
                sel_req    = bus_io.in_req[i];
                sel_valid  = bus_io.in_valid[i];
                sel_data   = bus_io.in_data[i*8 +: 8];
                sel_source = bus_io.in_source[i*8 +: 8];
            end
        end
    end

    assign xfer = (state_q == StActive) && sel_valid && bus_io.merged_ready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        stall_d     = stall_q;

        bus_io.merged_req     = 1'b0;
        bus_io.merged_valid   = 1'b0;
        bus_io.merged_data    = 8'h00;
        bus_io.merged_source  = 8'h00;
        bus_io.in_ready       = '0;
        bus_io.active_channel = 3'd0;
        bus_io.timeout_pulse  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d     = StActive;
                    grant_idx_d = pick_idx;
                    rr_ptr_d    = 3'((32'(pick_idx) + 1) % NUM_CHANNELS);
                    stall_d     = 16'd0;
                end
            end
            StActive: begin
                bus_io.merged_req     = 1'b1;
                bus_io.merged_valid   = sel_valid;
                bus_io.merged_data    = sel_data;
                bus_io.merged_source  = sel_source;
                bus_io.active_channel = grant_idx_q;
                for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                    if (32'(grant_idx_q) == i) begin
                        bus_io.in_ready[i] = bus_io.merged_ready;
                    end
                end

                if (xfer) begin
                    stall_d = 16'd0;
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end

                // Request drop outranks the watchdog; a same-cycle transfer still completes.
                if (!sel_req) begin
                    state_d = StRelease;
                end else if (!xfer && (stall_q == TIMEOUT_CYCLES - 16'd1)) begin
                    state_d              = StRelease;
                    bus_io.timeout_pulse = 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 3'd0;
            grant_idx_q <= 3'd0;
            stall_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            stall_q     <= stall_d;
        end
    end
endmodule

// File: tb/tb_upload_arbiter.sv
// Bench for upload_arbiter: directed frames plus randomized traffic against a
// transaction-level ownership model checked every cycle.
module tb_upload_arbiter;
    localparam int unsigned N = 3;
    localparam logic [15:0] T = 16'd8;

    logic clk;
    logic rst_n;

    upload_arbiter_if #(.NUM_CHANNELS(N)) bus ();

    upload_arbiter #(
        .NUM_CHANNELS  (N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: which channel owns the stream (-1 none), pending gap, next-first channel, stall age.
    int m_owner = -1;
    bit m_gap = 1'b0;
    int m_rr = 0;
    int m_stall = 0;

    logic [7:0] model_log[$];
    logic [7:0] dut_log[$];
    logic [7:0] fb[8];
    logic [7:0] seen_src;
    logic [2:0] seen_ac;

    bit rec_req[64];
    bit rec_to[64];
    logic [2:0] rec_ac[64];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_gap = 1'b0;
                m_rr = 0;
                m_stall = 0;
            end else if (m_owner >= 0) begin
                bit x;
                x = bus.in_valid[m_owner] && bus.merged_ready;
                if (x) model_log.push_back(bus.in_data[m_owner*8 +: 8]);
                if (!bus.in_req[m_owner]) begin
                    m_owner = -1;
                    m_gap = 1'b1;
                end else if (!x && m_stall == int'(T) - 1) begin
                    m_owner = -1;
                    m_gap = 1'b1;
                end else begin
                    m_stall = x ? 0 : ((m_stall < 65535) ? m_stall + 1 : m_stall);
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else begin
                for (int k = 0; k < int'(N); k++) begin
                    int c;
                    c = (m_rr + k) % int'(N);
                    if (bus.in_req[c]) begin
                        m_owner = c;
                        m_rr = (c + 1) % int'(N);
                        m_stall = 0;
                        break;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            logic [N-1:0] e_rdy;
            logic e_req, e_val, e_to;
            logic [7:0] e_d, e_s;
            logic [2:0] e_ac;
            @(negedge clk);
            e_rdy = '0; e_req = 0; e_val = 0; e_to = 0; e_d = 0; e_s = 0; e_ac = 0;
            if (m_owner >= 0) begin
                e_req = 1'b1;
                e_val = bus.in_valid[m_owner];
                e_d = bus.in_data[m_owner*8 +: 8];
                e_s = bus.in_source[m_owner*8 +: 8];
                e_rdy[m_owner] = bus.merged_ready;
                e_ac = 3'(m_owner);
                e_to = bus.in_req[m_owner] && !(e_val && bus.merged_ready) &&
                       (m_stall == int'(T) - 1);
            end
            chk("merged_req", 32'(bus.merged_req), 32'(e_req));
            chk("merged_valid", 32'(bus.merged_valid), 32'(e_val));
            chk("merged_data", 32'(bus.merged_data), 32'(e_d));
            chk("merged_source", 32'(bus.merged_source), 32'(e_s));
            chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
            chk("active_channel", 32'(bus.active_channel), 32'(e_ac));
            chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(e_to));
            if (bus.merged_req && bus.merged_valid && bus.merged_ready)
                dut_log.push_back(bus.merged_data);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.in_req = '0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.in_source = '0;
        bus.merged_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("reset_merged_req", 32'(bus.merged_req), 0);
        chk("reset_in_ready", 32'(bus.in_ready), 0);
        chk("reset_active_channel", 32'(bus.active_channel), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_log.delete();
        dut_log.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int ch, input logic [7:0] src, input int n,
                             input bit drop_last, input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit rdy = 1'b1;
        bit acc;
        bus.in_source[ch*8 +: 8] = src;
        bus.in_valid[ch] = 1'b1;
        while (idx < n && cyc < 200) begin
            bus.in_data[ch*8 +: 8] = fb[idx];
            bus.in_req[ch] = !(drop_last && idx == n - 1);
            bus.merged_ready = toggle ? rdy : 1'b1;
            @(negedge clk);
            acc = bus.in_ready[ch] && bus.in_valid[ch];
            if (bus.merged_req) begin
                seen_src = bus.merged_source;
                seen_ac = bus.active_channel;
            end
            tick();
            if (acc) idx++;
            rdy = !rdy;
            cyc++;
        end
        chk("frame_done", 32'(idx), 32'(n));
        bus.in_req[ch] = 1'b0;
        bus.in_valid[ch] = 1'b0;
        bus.merged_ready = 1'b1;
    endtask

    initial begin
        int got;
        int cyc;
        bit acc;
        int vmode;
        rst_n = 1'b1;
        clear_inputs();
        #1;

        // Single frame on ch1 with release gap.
        do_reset();
        fb[0] = 8'hAA; fb[1] = 8'h44; fb[2] = 8'h03; fb[3] = 8'h00;
        fb[4] = 8'h02; fb[5] = 8'h11; fb[6] = 8'h22; fb[7] = 8'hCC;
        run_frame(1, 8'h03, 8, 1'b0, 1'b0);
        @(negedge clk);
        chk("frame_tail_active", 32'(bus.merged_req), 1);
        tick();
        bus.in_req[1] = 1'b1;
        @(negedge clk);
        chk("release_gap", 32'(bus.merged_req), 0);
        tick();
        @(negedge clk);
        chk("idle_after_release", 32'(bus.merged_req), 0);
        tick();
        @(negedge clk);
        chk("regrant", 32'(bus.merged_req), 1);
        tick();
        bus.in_req[1] = 1'b0;
        repeat (3) tick();
        chk("f1_source", 32'(seen_src), 32'h03);
        chk("f1_channel", 32'(seen_ac), 1);
        chk("f1_dut_count", 32'(dut_log.size()), 8);
        chk("f1_model_count", 32'(model_log.size()), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++) chk("f1_byte", 32'(dut_log[i]), 32'(fb[i]));
        for (int i = 0; i < 8 && i < model_log.size(); i++)
            chk("f1_model_byte", 32'(model_log[i]), 32'(fb[i]));

        // Backpressure: ready toggles during a 6-byte frame.
        do_reset();
        for (int i = 0; i < 6; i++) fb[i] = 8'(8'h10 + i);
        run_frame(0, 8'h5A, 6, 1'b0, 1'b1);
        repeat (3) tick();
        chk("bp_dut_count", 32'(dut_log.size()), 6);
        chk("bp_model_count", 32'(model_log.size()), 6);
        for (int i = 0; i < 6 && i < dut_log.size(); i++) chk("bp_byte", 32'(dut_log[i]), 32'(fb[i]));

        // Req drop coinciding with final transfer.
        do_reset();
        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
        run_frame(2, 8'h77, 4, 1'b1, 1'b0);
        repeat (3) tick();
        chk("droplast_count", 32'(dut_log.size()), 4);
        if (dut_log.size() == 4) chk("droplast_byte", 32'(dut_log[3]), 32'h04);

        // Timeout revocation and round-robin alternation, both requesting, never valid.
        do_reset();
        bus.in_req[0] = 1'b1;
        bus.in_req[1] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rec_req[c] = bus.merged_req;
            rec_ac[c] = bus.active_channel;
            rec_to[c] = bus.timeout_pulse;
            tick();
        end
        chk("rr_idle0", 32'(rec_req[0]), 0);
        chk("rr_latency", 32'(rec_req[1]), 1);
        chk("rr_grant0", 32'(rec_ac[1]), 0);
        chk("to_not_early", 32'(rec_to[7]), 0);
        chk("to_pulse", 32'(rec_to[8]), 1);
        chk("to_release", 32'(rec_req[9]), 0);
        chk("to_idle", 32'(rec_req[10]), 0);
        chk("rr_grant1", 32'(rec_ac[11]), 1);
        chk("rr_grant1_req", 32'(rec_req[11]), 1);
        chk("to_pulse2", 32'(rec_to[18]), 1);
        chk("rr_grant2", 32'(rec_ac[21]), 0);
        chk("rr_grant2_req", 32'(rec_req[21]), 1);
        chk("rr_grant3", 32'(rec_ac[31]), 1);

        // Req drop on the watchdog cycle: no pulse.
        do_reset();
        bus.in_req[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) bus.in_req[0] = 1'b0;
            @(negedge clk);
            if (c == 8) begin
                chk("drop_vs_to_active", 32'(bus.merged_req), 1);
                chk("drop_vs_to_pulse", 32'(bus.timeout_pulse), 0);
            end
            if (c == 9) chk("drop_vs_to_release", 32'(bus.merged_req), 0);
            tick();
        end

        // Reset mid-frame after 3 of 8 bytes.
        do_reset();
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'hA0 + i);
        bus.in_req[1] = 1'b1;
        bus.in_valid[1] = 1'b1;
        bus.in_source[15:8] = 8'h42;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 50) begin
            bus.in_data[15:8] = fb[got];
            @(negedge clk);
            acc = bus.in_ready[1] && bus.in_valid[1];
            tick();
            if (acc) got++;
            cyc++;
        end
        bus.in_data[15:8] = fb[3];
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(bus.merged_req), 0);
        chk("midrst_valid", 32'(bus.merged_valid), 0);
        chk("midrst_data", 32'(bus.merged_data), 0);
        chk("midrst_source", 32'(bus.merged_source), 0);
        chk("midrst_ready", 32'(bus.in_ready), 0);
        chk("midrst_ac", 32'(bus.active_channel), 0);
        chk("midrst_count", 32'(dut_log.size()), 3);
        tick();
        rst_n = 1'b1;
        bus.in_valid[1] = 1'b0;
        bus.in_req[0] = 1'b1;
        @(negedge clk);
        chk("postrst_idle", 32'(bus.merged_req), 0);
        tick();
        @(negedge clk);
        chk("postrst_req", 32'(bus.merged_req), 1);
        chk("postrst_ch0", 32'(bus.active_channel), 0);
        tick();
        chk("postrst_no_xfer", 32'(dut_log.size()), 3);

        // Randomized traffic with occasional resets and long stalls.
        do_reset();
        vmode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) vmode = int'($urandom_range(0, 2));
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 7) == 0) bus.in_req[i] = ~bus.in_req[i];
                case (vmode)
                    0: bus.in_valid[i] = ($urandom_range(0, 9) != 0);
                    1: bus.in_valid[i] = ($urandom_range(0, 9) < 3);
                    default: bus.in_valid[i] = 1'b0;
                endcase
                bus.in_data[i*8 +: 8] = 8'($urandom);
                bus.in_source[i*8 +: 8] = 8'($urandom);
            end
            bus.merged_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n = 1'b1;
        clear_inputs();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
